// File: rtl/fetch_unit.sv
// Instruction fetch with a 2-entry prefetch FIFO and one-outstanding-request memory handshake.
// Optional stall counter output enabled by defining FETCH_STATS_EN.
module fetch_unit #(
  parameter int INSTR_WIDTH = 16,
  parameter int PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pc_load,
  input  logic [PC_WIDTH-1:0]    pc_load_value,
  output logic                   prog_req,
  output logic [PC_WIDTH-1:0]    prog_addr,
  input  logic                   prog_ack,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t                 state_reg, state_next;
  logic [1:0]             count_reg;
  logic [PC_WIDTH-1:0]    fetch_pc_reg;
  logic [INSTR_WIDTH-1:0] data_reg [2];
  logic [PC_WIDTH-1:0]    pc_reg [2];

  logic       pop;
  logic       push;
  logic [1:0] count_after_pop;

  assign instr_valid     = (count_reg != 2'd0);
  assign instr           = data_reg[0];
  assign instr_pc        = pc_reg[0];
  assign pop             = instr_valid && instr_ready;
  assign count_after_pop = count_reg - {1'b0, pop};
  assign push            = (state_reg == REQ) && prog_ack && !pc_load;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pc_load || count_after_pop <= 2'd1) state_next = REQ;
      end
      REQ: begin
        if (pc_load)       state_next = prog_ack ? REQ : DROP;
        // After the push the FIFO holds count_after_pop+1 entries.
        else if (prog_ack) state_next = (count_after_pop == 2'd0) ? REQ : IDLE;
      end
      DROP: begin
        if (prog_ack && !pc_load) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    prog_req  = (state_reg != IDLE);
    prog_addr = fetch_pc_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg    <= '0;
      fetch_pc_reg <= RESET_PC;
      for (int i = 0; i < 2; i++) begin
        data_reg[i] <= '0;
        pc_reg[i]   <= '0;
      end
    end else begin
      if (pc_load)   fetch_pc_reg <= pc_load_value;
      else if (push) fetch_pc_reg <= fetch_pc_reg + PC_WIDTH'(1);

      if (pc_load) count_reg <= '0;
      else         count_reg <= count_after_pop + {1'b0, push};

      // Shift on pop; a same-cycle push lands at the slot freed by the pop.
      if (pop) begin
        data_reg[0] <= data_reg[1];
        pc_reg[0]   <= pc_reg[1];
      end
      if (push) begin
        data_reg[count_after_pop[0]] <= prog_data;
        pc_reg[count_after_pop[0]]   <= fetch_pc_reg;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] stall_reg;

  always_ff @(posedge clk) begin
    if (reset)                                         stall_reg <= '0;
    else if (!instr_valid && stall_reg != 16'hFFFF)    stall_reg <= stall_reg + 16'd1;
  end

  assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder plus expected-PC stream model, directed and random phases.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_load;
  logic [9:0]  pc_load_value;
  logic        prog_req;
  logic [9:0]  prog_addr;
  logic        prog_ack;
  logic [15:0] prog_data;
  logic [15:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef FETCH_STATS_EN
  logic [15:0] stall_cycles;
`endif

  fetch_unit dut (
    .clk(clk), .reset(reset), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .prog_req(prog_req), .prog_addr(prog_addr), .prog_ack(prog_ack), .prog_data(prog_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef FETCH_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory responder state: lat < 0 means random 0..3 wait cycles per request.
  int   lat = 0;
  bit   mem_en = 1'b1;
  bit   busy = 1'b0;
  int   wcnt = 0;
  int   acks = 0;
  bit   force_ack = 1'b0;

  // Consumer model: the next instruction the consumer must receive.
  logic [9:0] exp_pc = 10'd0;
  int         pops = 0;
  logic [9:0] last_pc = 10'd0;
  bit         have_last = 1'b0;
  bit         wrap_seen = 1'b0;

  function automatic logic [15:0] mem_word(input logic [9:0] a);
    int unsigned v;
    v = (int'(a) * 40503 + 4660) ^ (int'(a) << 7);
    return v[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit rdy, input bit ld, input logic [9:0] ldv);
    @(negedge clk);
    reset         = rst;
    instr_ready   = rst ? 1'b0 : rdy;
    pc_load       = ld;
    pc_load_value = ldv;
    prog_ack      = 1'b0;
    prog_data     = '0;
    if (rst) begin
      busy = 1'b0;
    end else if (force_ack) begin
      prog_ack  = 1'b1;
      prog_data = 16'hDEAD;
    end else if (mem_en && prog_req) begin
      if (!busy) begin
        busy = 1'b1;
        wcnt = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      end
      if (wcnt == 0) begin
        prog_ack  = 1'b1;
        prog_data = mem_word(prog_addr);
        busy      = 1'b0;
        acks++;
      end else begin
        wcnt--;
      end
    end
    #1;
    if (!rst && instr_valid && instr_ready) begin
      check("pop_pc", 32'(instr_pc), 32'(exp_pc));
      check("pop_data", 32'(instr), 32'(mem_word(instr_pc)));
      $display("pop pc=%03h instr=%04h", instr_pc, instr);
      if (have_last && last_pc == 10'h3FF && instr_pc == 10'h000) wrap_seen = 1'b1;
      last_pc   = instr_pc;
      have_last = 1'b1;
      pops++;
      exp_pc = exp_pc + 10'd1;
    end
    if (!rst && ld) exp_pc = ldv;
    if (rst) begin
      exp_pc    = 10'd0;
      have_last = 1'b0;
    end
  endtask

  initial begin
    int p0;
    int a0;
    reset = 1'b1; pc_load = 1'b0; pc_load_value = '0;
    prog_ack = 1'b0; prog_data = '0; instr_ready = 1'b0;

    // Reset state
    repeat (3) cycle(1, 0, 0, 10'd0);
    check("rst_prog_req", 32'(prog_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
`ifdef FETCH_STATS_EN
    check("rst_stall", 32'(stall_cycles), 32'd0);
`endif

    // Zero-wait memory, consumer always ready
    lat = 0;
    cycle(0, 1, 0, 10'd0);
    check("c1_prog_req", 32'(prog_req), 32'd0);
    cycle(0, 1, 0, 10'd0);
    check("c2_prog_req", 32'(prog_req), 32'd1);
    check("c2_prog_addr", 32'(prog_addr), 32'd0);
    check("c2_valid", 32'(instr_valid), 32'd0);
    cycle(0, 1, 0, 10'd0);
    check("c3_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 0, 10'd0);
      check("stream_valid", 32'(instr_valid), 32'd1);
    end
    check("stream_pops", 32'(pops), 32'd21);
`ifdef FETCH_STATS_EN
    check("stream_stall", 32'(stall_cycles), 32'd2);
`endif

    // Consumer stalls: FIFO fills to two entries and requests stop
    cycle(0, 0, 0, 10'd0);
    cycle(0, 0, 0, 10'd0);
    a0 = acks;
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 10'd0);
    check("stall_acks", 32'(acks - a0), 32'd0);
    check("stall_prog_req", 32'(prog_req), 32'd0);
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_head_pc", 32'(instr_pc), 32'(exp_pc));
    mem_en = 1'b0;
    p0 = pops;
    repeat (4) cycle(0, 1, 0, 10'd0);
    check("stall_buffered", 32'(pops - p0), 32'd2);
    check("drained_valid", 32'(instr_valid), 32'd0);
    mem_en = 1'b1;
    repeat (5) cycle(0, 1, 0, 10'd0);

    // Random latency, back-pressure and redirects
    lat = -1;
    p0 = pops;
    for (int i = 0; i < 800; i++) begin
      cycle(0, ($urandom % 10) < 7, ($urandom % 32) == 0, 10'($urandom));
    end
    check("random_progress", 32'(pops - p0 >= 100), 32'd1);

    // Redirect during a 3-cycle wait: stale response discarded
    repeat (2) cycle(1, 0, 0, 10'd0);
    lat = 3;
    cycle(0, 1, 0, 10'd0);
    cycle(0, 1, 0, 10'd0);
    check("d_c2_req", 32'(prog_req), 32'd1);
    check("d_c2_ack", 32'(prog_ack), 32'd0);
    cycle(0, 1, 1, 10'h155);
    cycle(0, 1, 0, 10'd0);
    check("d_c4_req", 32'(prog_req), 32'd1);
    check("d_c4_ack", 32'(prog_ack), 32'd0);
    cycle(0, 1, 0, 10'd0);
    check("d_c5_stale_ack", 32'(prog_ack), 32'd1);
    cycle(0, 1, 0, 10'd0);
    check("d_c6_addr", 32'(prog_addr), 32'h155);
    check("d_c6_valid", 32'(instr_valid), 32'd0);
    p0 = pops;
    for (int i = 0; i < 20 && pops == p0; i++) cycle(0, 1, 0, 10'd0);
    check("d_got_pop", 32'(pops > p0), 32'd1);
    check("d_first_pc", 32'(last_pc), 32'h155);

    // PC wrap at the top of the address space
    lat = 0;
    wrap_seen = 1'b0;
    cycle(0, 1, 1, 10'h3FE);
    repeat (6) cycle(0, 1, 0, 10'd0);
    check("wrap_3ff_to_0", 32'(wrap_seen), 32'd1);

    // Reset with a request in flight and one entry buffered
    repeat (2) cycle(1, 0, 0, 10'd0);
    lat = 2;
    repeat (4) cycle(0, 0, 0, 10'd0);
    cycle(1, 0, 0, 10'd0);
    check("r_pre_valid", 32'(instr_valid), 32'd1);
    check("r_pre_req", 32'(prog_req), 32'd1);
    force_ack = 1'b1;
    cycle(0, 0, 0, 10'd0);
    check("r_post_req", 32'(prog_req), 32'd0);
    check("r_post_valid", 32'(instr_valid), 32'd0);
    force_ack = 1'b0;
    cycle(0, 0, 0, 10'd0);
    check("r_late_ack_ignored", 32'(instr_valid), 32'd0);
    check("r_req_restart", 32'(prog_req), 32'd1);
    check("r_req_addr", 32'(prog_addr), 32'd0);
    p0 = pops;
    for (int i = 0; i < 20 && pops == p0; i++) cycle(0, 1, 0, 10'd0);
    check("r_got_pop", 32'(pops > p0), 32'd1);
    check("r_first_pc", 32'(last_pc), 32'd0);

`ifdef FETCH_STATS_EN
    // Starved memory: stall counter saturates
    repeat (2) cycle(1, 0, 0, 10'd0);
    mem_en = 1'b0;
    for (int i = 0; i < 70000; i++) cycle(0, 1, 0, 10'd0);
    check("stats_sat", 32'(stall_cycles), 32'hFFFF);
    repeat (3) cycle(0, 1, 0, 10'd0);
    check("stats_hold", 32'(stall_cycles), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
